// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one fetch at a time to instruction memory and
// buffers returned words in a circular buffer. A redirect flushes it and refetches.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [63:0]              mem_addr,
  input  logic                     mem_resp_valid,
  input  logic [31:0]              mem_resp_instr,
  output logic                     out_valid,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] Full = DEPTH[PtrW:0];

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e            state_q;
  logic [63:0]       fetch_pc_q;
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]     count_q;
  logic [63:0]       pc_mem    [DEPTH];
  logic [31:0]       instr_mem [DEPTH];
  logic              issue, push, pop;

  // Redirect outranks push and pop; reset outranks everything.
  always_comb begin
    issue = !reset && !redirect_valid && (state_q == StIdle) && (count_q != Full);
    push  = !reset && !redirect_valid && (state_q == StWait) && mem_resp_valid;
    pop   = !reset && !redirect_valid && (count_q != '0) && out_ready;
  end

  always_comb begin
    mem_req   = issue;
    mem_addr  = fetch_pc_q;
    out_valid = !reset && (count_q != '0);
    out_pc    = pc_mem[rd_ptr_q];
    out_instr = instr_mem[rd_ptr_q];
    count     = reset ? '0 : count_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      instr_mem[wr_ptr_q] <= mem_resp_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (push) begin
          wr_ptr_q   <= wr_ptr_q + 1'b1;
          fetch_pc_q <= fetch_pc_q + 64'd4;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        unique case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end

      // Any response ends the outstanding fetch; it is kept only when not stale.
      unique case (state_q)
        StIdle:    if (issue) state_q <= StWait;
        StWait: begin
          if (mem_resp_valid)      state_q <= StIdle;
          else if (redirect_valid) state_q <= StDiscard;
        end
        StDiscard: if (mem_resp_valid) state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a latency-configurable memory model, a queue-based reference
// model of the fetch/flush rules, and a monitor comparing DUT outputs each cycle.
module tb_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic                   clk = 1'b0;
  logic                   reset, mem_req, mem_resp_valid, out_valid, out_ready, redirect_valid;
  logic [63:0]            mem_addr, out_pc, redirect_pc;
  logic [31:0]            mem_resp_instr, out_instr;
  logic [$clog2(DEPTH):0] count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_instr (mem_resp_instr),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .count          (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [63:0] pc; logic [31:0] instr;} entry_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          req_count = 0;
  int          due_q[$];
  logic [63:0] addr_q[$];

  // Reference model: expected queue contents, fetch pc, outstanding/stale flags.
  entry_t      exp_q[$];
  logic [63:0] m_pc;
  bit          m_busy, m_stale, can_issue, exp_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (reset) begin
      exp_q.delete();
      m_pc = RESET_PC; m_busy = 0; m_stale = 0;
    end else begin
      can_issue = !m_busy && (exp_q.size() < DEPTH);
      if (redirect_valid) begin
        exp_q.delete();
        m_pc = redirect_pc;
        if (m_busy) begin
          if (mem_resp_valid) begin m_busy = 0; m_stale = 0; end
          else m_stale = 1;
        end
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (m_busy && mem_resp_valid) begin
          if (!m_stale) begin
            exp_q.push_back({m_pc, mem_resp_instr});
            m_pc = m_pc + 64'd4;
          end
          m_busy = 0; m_stale = 0;
        end else if (can_issue) begin
          m_busy = 1;
        end
      end
    end
  end

  // Monitor: compares outputs mid-cycle and records memory requests.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_mem_req", 64'(mem_req), 64'd0);
    end else begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      exp_req = !m_busy && (exp_q.size() < DEPTH) && !redirect_valid;
      chk("mem_req", 64'(mem_req), 64'(exp_req));
      if (mem_req) chk("mem_addr", mem_addr, m_pc);
      if (out_valid && out_ready && !redirect_valid && exp_q.size() != 0) begin
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
      end
    end
    if (mem_req && !reset) begin
      req_count++;
      due_q.push_back(cyc + lat);
      addr_q.push_back(mem_addr);
    end
  end

  // Advance one cycle; drives any memory response due this cycle.
  task automatic tick();
    logic [63:0] a;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    mem_resp_valid = 1'b0;
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      a = addr_q.pop_front();
      void'(due_q.pop_front());
      mem_resp_valid = 1'b1;
      mem_resp_instr = 32'hA000_0000 | a[31:0];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; out_ready = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
  endtask

  int base;
  bit found;

  initial begin
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mem_resp_valid = 1'b0; mem_resp_instr = '0;

    // Streaming with 1-cycle memory: one request every two cycles.
    lat = 1; do_reset(); out_ready = 1'b1;
    base = req_count;
    repeat (40) tick();
    chk("stream_req_rate", 64'(req_count - base), 64'd20);

    // Back-pressure fills the queue, then a single pop frees one slot.
    do_reset(); out_ready = 1'b0;
    base = req_count;
    repeat (20) tick();
    @(negedge clk);
    chk("full_count", 64'(count), 64'd4);
    chk("full_reqs", 64'(req_count - base), 64'd4);
    tick(); out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_count", 64'(count), 64'd3);
    chk("after_pop_addr", mem_addr, 64'h10);
    repeat (6) tick();
    chk("after_pop_reqs", 64'(req_count - base), 64'd5);

    // 3-cycle memory, redirect while the fetch at 0x8 is outstanding.
    lat = 3; do_reset(); out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick(); @(negedge clk);
      if (mem_req && mem_addr == 64'h8) found = 1;
    end
    chk("redir_req8_seen", 64'(found), 64'd1);
    tick(); redirect_valid = 1'b1; redirect_pc = 64'h100;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(); @(negedge clk);
      if (mem_req) begin found = 1; chk("redir_next_addr", mem_addr, 64'h100); end
      else chk("redir_flush_count", 64'(count), 64'd0);
    end
    chk("redir_req_seen", 64'(found), 64'd1);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(); @(negedge clk);
      if (out_valid) begin found = 1; chk("redir_first_pc", out_pc, 64'h100); end
    end
    chk("redir_out_seen", 64'(found), 64'd1);

    // Redirect coinciding with a response while two entries are queued.
    lat = 1; do_reset(); out_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(); @(negedge clk);
      if (mem_req && count == 2) found = 1;
    end
    chk("coinc_setup", 64'(found), 64'd1);
    tick(); redirect_valid = 1'b1; redirect_pc = 64'h200; out_ready = 1'b1;
    @(negedge clk);
    chk("coinc_pre_count", 64'(count), 64'd2);
    tick();
    @(negedge clk);
    chk("coinc_count", 64'(count), 64'd0);
    chk("coinc_req", 64'(mem_req), 64'd1);
    chk("coinc_addr", mem_addr, 64'h200);

    // Randomised traffic: back-pressure, redirects (some near 2^64), sporadic reset.
    lat = 2; do_reset();
    repeat (12) tick();
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                                  : 64'($urandom_range(0, 1023)) << 2;
      end
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
    end
    reset = 1'b0;

    // Reset while a fetch is outstanding; old response lands after release.
    lat = 3; do_reset(); out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(); @(negedge clk);
      if (mem_req) found = 1;
    end
    chk("rst_wait_setup", 64'(found), 64'd1);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("rst_wait_req", 64'(mem_req), 64'd1);
    chk("rst_wait_addr", mem_addr, RESET_PC);
    chk("rst_wait_count", 64'(count), 64'd0);
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
